fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage. It sits directly downstream of the branch/jump resolution unit, consuming that unit's redirect target (newPC), fetch-control strobe (ctrlFetch) and pipeline flush (global_reset). It owns the program counter and issues single-outstanding requests to instruction memory. Fetched {pc, instr} pairs are buffered in a small FIFO and handed to decode through a valid/ready handshake.

Parameters:
XLEN, 32, address/instruction width
RESET_PC, 32'h0000_0000, fetch PC after reset
FIFO_DEPTH, 2, fetch buffer entries (power of two, >=2)
PC_STEP, 4, sequential PC increment in bytes

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-high
ctrl_fetch  in  1  redirect strobe from jump unit; load new_pc
new_pc  in  XLEN  redirect target; valid when ctrl_fetch=1
flush  in  1  pipeline flush from jump unit (global_reset)
imem_req  out  1  one-cycle request pulse
imem_addr  out  XLEN  request address; valid with imem_req
imem_valid  in  1  response strobe, >=1 cycle after imem_req
imem_rdata  in  XLEN  instruction word; valid with imem_valid
out_valid  out  1  buffer head valid toward decode
out_ready  in  1  decode accepts head
out_instr  out  XLEN  head instruction
out_pc  out  XLEN  head instruction address

Behaviour:
- Reset: pc=RESET_PC, FIFO empty, state=IDLE, imem_req=0, imem_addr=0, out_valid=0, out_instr=0, out_pc=0. Reset overrides all other inputs. Asserting reset mid-request abandons the request; any later imem_valid while in IDLE is ignored.
- State machine has three states:
  - IDLE: no request outstanding. Issue when count+0 < FIFO_DEPTH and no ctrl_fetch/flush this cycle. Issue means imem_req=1, imem_addr=pc, latch req_pc=pc, pc<=pc+PC_STEP, go to WAIT. Otherwise stay.
  - WAIT: one request in flight. On imem_valid: enqueue {req_pc, imem_rdata`}`, go to IDLE. Room is guaranteed because issue reserved a slot. On ctrl_fetch or flush before imem_valid: go to DROP. On ctrl_fetch or flush in the same cycle as imem_valid: discard the response and go to IDLE.
  - DROP: in-flight response must be discarded. On imem_valid: discard and go to IDLE. A further redirect in DROP only updates pc.
- Issue never occurs in WAIT or DROP, so at most one request is outstanding. Minimum issue interval is 2 cycles (IDLE→WAIT→IDLE).
- Redirect (ctrl_fetch=1): pc<=new_pc with bits[1:0] forced to 0. FIFO is cleared and out_valid=0 next cycle. The decode handshake is ignored in that cycle.
- Flush without ctrl_fetch: FIFO is cleared and in-flight data is dropped. pc rewinds so no instruction is lost:
  - FIFO non-empty → pc<=head pc.
  - Otherwise, in WAIT → pc<=req_pc.
  - Otherwise → pc unchanged.
- ctrl_fetch together with flush: redirect takes precedence for pc.
- FIFO: enqueue and dequeue in the same cycle are both permitted. Dequeue occurs when out_valid & out_ready. out_* are driven from the head entry, registered, with no combinational path from imem_rdata. Data enters the FIFO 1 cycle after imem_valid. Empty → out_valid=0 and out_instr/out_pc hold their last value. Full (count==FIFO_DEPTH) → no issue.
- Arithmetic: pc+PC_STEP is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
- Reservation: the issue condition is count + (state!=IDLE) < FIFO_DEPTH. The request in flight counts as occupied.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN and RESET_PC defaults.
  - Fetch state encoding: FETCH_IDLE=2'd0, FETCH_WAIT=2'd1, FETCH_DROP=2'd2.
  - Fetch entry struct {pc, instr}.
- One sub-module: fetch_fifo, a parameterised sync FIFO with push/pop/clear, count, head and full/empty outputs. The top level holds the PC register and the state machine.

Test Plan:
- Reset with RESET_PC=0, memory latency 1, out_ready=1 → addresses 0,4,8,12 requested every 2 cycles; out_pc sequence 0,4,8,12 with the matching instr words.
- out_ready=0 for 10 cycles → exactly 2 requests issued (FIFO_DEPTH=2), then imem_req stays 0. Release → entries drain in order and fetching resumes at 8.
- ctrl_fetch=1, new_pc=32'h100, asserted while WAIT with latency 3 → response discarded, out_valid=0, next imem_addr=32'h100, first out_pc=32'h100.
- ctrl_fetch and imem_valid in the same cycle, new_pc=32'h203 → response dropped, next imem_addr=32'h200.
- flush alone with FIFO holding pc 8,12 → FIFO cleared, next imem_addr=8.
- pc=32'hFFFF_FFFC sequential fetch → next imem_addr=0. Reset asserted in WAIT, then a stale imem_valid → nothing enqueued, first request at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants, fetch state encoding and fetch buffer entry type
package cpu_pkg;
    localparam int CPU_XLEN = 32;
    localparam logic [CPU_XLEN-1:0] CPU_RESET_PC = 32'h0000_0000;
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_e;
    typedef struct packed {
        logic [CPU_XLEN-1:0] pc;
        logic [CPU_XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with clear; head is read straight from storage registers
// Ports: clock/reset, clear (drop all entries), push+din, pop, head (oldest entry),
//        count, full, empty.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    push,
    input  logic                    pop,
    input  logic [W-1:0]            din,
    output logic [W-1:0]            head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0] cnt_q;
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            rd_q <= '0;
            wr_q <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= din;
                wr_q <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
    assign head = mem_q[rd_q];
    assign count = cnt_q;
    assign full = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage owning the PC, one outstanding imem request, buffered output to decode
// Ports: clock/reset; ctrl_fetch+new_pc redirect and flush from the jump unit;
//        imem_req/imem_addr request, imem_valid/imem_rdata response;
//        out_valid/out_ready handshake with out_instr/out_pc toward decode.
module fetch_unit import cpu_pkg::*; #(
    parameter int XLEN = CPU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = CPU_RESET_PC,
    parameter int FIFO_DEPTH = 2,
    parameter int PC_STEP = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ctrl_fetch,
    input  logic [XLEN-1:0] new_pc,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
);
    fetch_state_e state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
    fetch_entry_t head_e, last_q, push_e;
    logic [$clog2(FIFO_DEPTH):0] cnt;
    logic full, empty, redirect, issue, push, pop;
    assign redirect = ctrl_fetch || flush;
    // The in-flight request holds a reserved slot, so its response always fits.
    assign issue = !reset && state_q == FETCH_IDLE && !redirect && !full
                   && (int'(cnt) + int'(state_q != FETCH_IDLE) < FIFO_DEPTH);
    assign push = state_q == FETCH_WAIT && imem_valid && !redirect;
    assign pop = !empty && out_ready && !redirect;
    assign push_e = '{pc: req_pc_q, instr: imem_rdata};
    fetch_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(fetch_entry_t))) u_fifo (
        .clock(clock),
        .reset(reset),
        .clear(redirect),
        .push(push),
        .pop(pop),
        .din(push_e),
        .head(head_e),
        .count(cnt),
        .full(full),
        .empty(empty)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH_IDLE;
            pc_q <= RESET_PC;
            req_pc_q <= '0;
            last_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            req_pc_q <= req_pc_d;
            last_q <= empty ? last_q : head_e;
        end
    end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH_IDLE: state_d = issue ? FETCH_WAIT : FETCH_IDLE;
            FETCH_WAIT: state_d = imem_valid ? FETCH_IDLE : redirect ? FETCH_DROP : FETCH_WAIT;
            FETCH_DROP: state_d = imem_valid ? FETCH_IDLE : FETCH_DROP;
            default:    state_d = FETCH_IDLE;
        endcase
    end
    // A flush rewinds to the oldest instruction not yet handed to decode.
    always_comb begin
        pc_d = ctrl_fetch ? {new_pc[XLEN-1:2], 2'b00}
             : flush ? (!empty ? head_e.pc : state_q == FETCH_WAIT ? req_pc_q : pc_q)
             : issue ? pc_q + XLEN'(PC_STEP) : pc_q;
        req_pc_d = issue ? pc_q : req_pc_q;
    end
    always_comb begin
        imem_req = issue;
        imem_addr = issue ? pc_q : '0;
    end
    // When empty, decode keeps seeing the last head that was presented.
    assign out_valid = !empty;
    assign out_pc = empty ? last_q.pc : head_e.pc;
    assign out_instr = empty ? last_q.instr : head_e.instr;
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    logic clock = 0, reset = 1, ctrl_fetch = 0, flush = 0, imem_valid = 0, out_ready = 0;
    logic [31:0] new_pc = 0, imem_rdata = 0;
    logic imem_req, out_valid;
    logic [31:0] imem_addr, out_instr, out_pc;
    int checks = 0, errors = 0;
    bit [31:0] m_pc, m_req_pc, mem_addr;
    bit m_pend, m_drop, m_known, mem_busy;
    int mem_cnt, lat = 1;
    logic [63:0] q[$];
    logic [63:0] m_last;

    fetch_unit dut (
        .clock(clock), .reset(reset), .ctrl_fetch(ctrl_fetch), .new_pc(new_pc), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ifn(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit c, input logic [31:0] np, input bit f, input bit rdy);
        bit redir, e_issue;
        bit [31:0] e_addr, nxt;
        @(negedge clock);
        reset = r; ctrl_fetch = c; new_pc = np; flush = f; out_ready = rdy;
        imem_valid = mem_busy && mem_cnt == 0;
        imem_rdata = imem_valid ? ifn(mem_addr) : $urandom;
        redir = c || f;
        e_issue = !r && !m_pend && q.size() < 2 && !redir;
        e_addr = e_issue ? m_pc : 32'h0;
        #1;
        if (m_known) begin
            check("imem_req", imem_req, e_issue);
            check("imem_addr", imem_addr, e_addr);
            check("out_valid", out_valid, q.size() > 0);
            check("out_pc", out_pc, q.size() > 0 ? q[0][63:32] : m_last[63:32]);
            check("out_instr", out_instr, q.size() > 0 ? q[0][31:0] : m_last[31:0]);
        end
        @(posedge clock);
        if (r) begin
            m_pc = 0; q.delete(); m_pend = 0; m_drop = 0; m_last = 0; m_known = 1;
        end else begin
            if (q.size() > 0) m_last = q[0];
            if (c) nxt = {np[31:2], 2'b00};
            else if (f) nxt = q.size() > 0 ? q[0][63:32] : (m_pend && !m_drop) ? m_req_pc : m_pc;
            else nxt = e_issue ? m_pc + 32'd4 : m_pc;
            if (redir) q.delete();
            else begin
                if (rdy && q.size() > 0) void'(q.pop_front());
                if (m_pend && !m_drop && imem_valid) q.push_back({m_req_pc, imem_rdata});
            end
            if (m_pend && imem_valid) begin m_pend = 0; m_drop = 0; end
            else if (m_pend && redir) m_drop = 1;
            if (e_issue) begin m_pend = 1; m_drop = 0; m_req_pc = m_pc; end
            m_pc = nxt;
        end
        if (imem_valid) mem_busy = 0;
        else if (mem_busy) mem_cnt--;
        if (e_issue) begin mem_busy = 1; mem_cnt = lat - 1; mem_addr = e_addr; end
    endtask

    initial begin
        int n;
        lat = 1;
        repeat (2) step(1, 0, 0, 0, 1);
        repeat (12) step(0, 0, 0, 0, 1);
        repeat (2) step(1, 0, 0, 0, 1);
        repeat (10) step(0, 0, 0, 0, 0);
        repeat (10) step(0, 0, 0, 0, 1);
        lat = 3;
        for (n = 0; n < 50 && !(m_pend && !m_drop); n++) step(0, 0, 0, 0, 1);
        check("wait_bound", n < 50, 1);
        step(0, 1, 32'h100, 0, 1);
        repeat (10) step(0, 0, 0, 0, 1);
        for (n = 0; n < 50 && !(m_pend && !m_drop && mem_busy && mem_cnt == 0); n++) step(0, 0, 0, 0, 1);
        check("wait_bound", n < 50, 1);
        step(0, 1, 32'h203, 0, 1);
        repeat (8) step(0, 0, 0, 0, 1);
        lat = 1;
        repeat (2) step(1, 0, 0, 0, 1);
        for (n = 0; n < 50 && q.size() < 2; n++) step(0, 0, 0, 0, 0);
        check("wait_bound", n < 50, 1);
        step(0, 0, 0, 1, 0);
        repeat (8) step(0, 0, 0, 0, 1);
        step(0, 1, 32'hFFFF_FFFC, 0, 1);
        repeat (8) step(0, 0, 0, 0, 1);
        lat = 3;
        for (n = 0; n < 50 && !(m_pend && !m_drop && mem_busy && mem_cnt == 2); n++) step(0, 0, 0, 0, 1);
        check("wait_bound", n < 50, 1);
        repeat (2) step(1, 0, 0, 0, 1);
        repeat (10) step(0, 0, 0, 0, 1);
        repeat (3000) begin
            lat = $urandom_range(1, 3);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0, $urandom,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
